// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Optional lap feature: define STOPWATCH_LAP_EN to add the LAP state.
package stopwatch_pkg;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;
`endif

  // Wrap values of the four BCD digits (tens digits stop at 5 for 0..59)
  localparam logic [3:0] SEC_T_MAX = 4'd5;
  localparam logic [3:0] MIN_T_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX  = 4'd9;

  // The prescaler and live count advance only in these states
  function automatic logic is_counting(input sw_state_t s);
`ifdef STOPWATCH_LAP_EN
    return (s == RUN) || (s == LAP);
`else
    return (s == RUN);
`endif
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit that counts 0..MAX and wraps; carry flags the wrap so the
// next digit up can advance in the same cycle.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = ONES_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_reg;

  // Digit register: clear wins over increment, wrap to 0 after MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 4'd0;
    end else if (clr) begin
      q_reg <= 4'd0;
    end else if (en) begin
      q_reg <= (q_reg == MAX) ? 4'd0 : q_reg + 4'd1;
    end
  end

  assign q     = q_reg;
  assign carry = en & (q_reg == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: start/stop/clear control FSM, one-second prescaler,
// BCD digit chain and optional lap freeze (macro STOPWATCH_LAP_EN).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       lap_hold,
  output logic       rollover
);

  localparam logic [31:0] PRESC_LAST = 32'(TICK_DIV - 1);

  sw_state_t   state_reg, state_next;
  logic [31:0] presc_reg;
  logic        counting;
  logic        tick;
  logic        tick_en;
  logic        capture;
  logic [15:0] live;
  logic        c_sec_o, c_sec_t, c_min_o, c_min_t;

  assign counting = is_counting(state_reg);
  assign tick     = counting && (presc_reg == PRESC_LAST);
  // A tick landing on a clear is thrown away
  assign tick_en  = tick & ~btn_clr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: clear beats start/stop, which beats lap
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    if (btn_clr) begin
      state_next = IDLE;
    end else if (btn_ss) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
`ifdef STOPWATCH_LAP_EN
        LAP:     state_next = PAUSE;
`endif
        default: state_next = IDLE;
      endcase
`ifdef STOPWATCH_LAP_EN
    end else if (btn_lap) begin
      if (state_reg == RUN) begin
        state_next = LAP;
        capture    = 1'b1;
      end else if (state_reg == LAP) begin
        state_next = RUN;
      end
`endif
    end
  end

  // Prescaler: zero in IDLE or on clear, hold in PAUSE, wrap on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= 32'd0;
    end else if (btn_clr || state_reg == IDLE) begin
      presc_reg <= 32'd0;
    end else if (counting) begin
      presc_reg <= tick ? 32'd0 : presc_reg + 32'd1;
    end
  end

  bcd_digit_cnt #(.MAX(ONES_MAX)) u_sec_o (
    .clk(clk), .rst_n(rst_n), .en(tick_en), .clr(btn_clr),
    .q(live[3:0]), .carry(c_sec_o)
  );
  bcd_digit_cnt #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .en(c_sec_o), .clr(btn_clr),
    .q(live[7:4]), .carry(c_sec_t)
  );
  bcd_digit_cnt #(.MAX(ONES_MAX)) u_min_o (
    .clk(clk), .rst_n(rst_n), .en(c_sec_t), .clr(btn_clr),
    .q(live[11:8]), .carry(c_min_o)
  );
  bcd_digit_cnt #(.MAX(MIN_T_MAX)) u_min_t (
    .clk(clk), .rst_n(rst_n), .en(c_min_o), .clr(btn_clr),
    .q(live[15:12]), .carry(c_min_t)
  );

  // Carry out of the top digit only happens on the 59:59 -> 00:00 tick
  assign rollover = c_min_t;
  assign running  = counting;

`ifdef STOPWATCH_LAP_EN
  logic [15:0] lap_reg;
  logic [15:0] disp;

  // Lap register: snapshot of the pre-increment live count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lap_reg <= 16'd0;
    else if (btn_clr) lap_reg <= 16'd0;
    else if (capture) lap_reg <= live;
  end

  assign lap_hold = (state_reg == LAP);
  assign disp     = lap_hold ? lap_reg : live;
  assign {min_t, min_o, sec_t, sec_o} = disp;
`else
  logic unused_lap;

  assign unused_lap = btn_lap ^ capture;
  assign lap_hold   = 1'b0;
  assign {min_t, min_o, sec_t, sec_o} = live;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per one-second tick; legal range 2..2^32-1.
REQ-002 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 btn_ss  input  1  start/stop request, one-cycle pulse, already debounced.
REQ-005 btn_clr  input  1  clear request, one-cycle pulse.
REQ-006 btn_lap  input  1  lap freeze/release request, one-cycle pulse.
REQ-007 min_t, min_o, sec_t, sec_o  output  4 each  displayed MM:SS as BCD digits.
REQ-008 running  output  1  high in RUN and LAP states.
REQ-009 lap_hold  output  1  high in LAP state; display frozen.
REQ-010 rollover  output  1  one-cycle pulse when the count wraps from 59:59 to 00:00.

Function
REQ-011 FSM states: IDLE, RUN, PAUSE, LAP; decisions use the current state, and the new state takes effect next cycle.
REQ-012 Same-cycle request priority SHALL be btn_clr > btn_ss > btn_lap; lower-priority requests in that cycle are dropped.
REQ-013 IDLE: btn_ss -> RUN; btn_clr -> IDLE; btn_lap ignored.
REQ-014 RUN: btn_ss -> PAUSE; btn_lap -> LAP with capture; btn_clr -> IDLE.
REQ-015 PAUSE: btn_ss -> RUN; btn_clr -> IDLE; btn_lap ignored.
REQ-016 LAP: btn_lap -> RUN (release); btn_ss -> PAUSE (release); btn_clr -> IDLE.
REQ-017 Prescaler counts 0..TICK_DIV-1 only in RUN/LAP; tick is asserted in the cycle it equals TICK_DIV-1, then wraps to 0.
REQ-018 Prescaler SHALL hold its value in PAUSE (resume continues the partial second) and be zeroed in IDLE and on btn_clr.
REQ-019 Each tick increments the live count: sec_o 0-9, sec_t 0-5, min_o 0-9, min_t 0-5; higher digit advances only on lower digit carry.
REQ-020 A tick at 59:59 SHALL produce 00:00 and assert rollover in that same cycle; counting continues.
REQ-021 A tick coinciding with btn_ss in RUN SHALL still be counted.
REQ-022 A tick coinciding with btn_clr SHALL be discarded; the count is 00:00 next cycle.
REQ-023 Lap capture latches the live count present in the capture cycle (pre-increment).
REQ-024 Display outputs = lap register when lap_hold, else live count; combinational mux, no extra latency.
REQ-025 Live count SHALL continue advancing in LAP.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, prescaler 0, live and lap registers 00:00, running=0, lap_hold=0, rollover=0, including mid-RUN or mid-LAP.
REQ-027 After rst_n deasserts, the block SHALL stay in IDLE until btn_ss is asserted.

Configuration
REQ-028 Macro STOPWATCH_LAP_EN defined: LAP state, lap register and btn_lap behave per REQ-014/016/023/024.
REQ-029 STOPWATCH_LAP_EN undefined: no LAP state or lap register; btn_lap is ignored in every state; lap_hold is tied 0; display = live count; port list unchanged.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum and digit limit constants (SEC_T_MAX=5, MIN_T_MAX=5, ONES_MAX=9).
REQ-031 Sub-module bcd_digit_cnt (parameter MAX; ports clk, rst_n, en, clr, q[3:0], carry = en & (q==MAX)) SHALL be instantiated four times as the digit chain.

Verification (TICK_DIV=4)
REQ-032 Reset, pulse btn_ss, run 40 cycles -> display 00:10, running=1, rollover never high.
REQ-033 Run to 00:03 plus 2 prescaler counts, btn_ss, hold 20 cycles, btn_ss -> display frozen at 00:03 during pause; 00:04 two cycles after resume.
REQ-034 Run to 00:05, btn_lap, run 20 more cycles -> display stays 00:05 with lap_hold=1; btn_lap -> display 00:10 next cycle.
REQ-035 Run 3600 ticks (14400 cycles) -> 59:59 to 00:00 transition with rollover high for exactly one cycle.
REQ-036 btn_clr and btn_ss in the same cycle during RUN at 00:07 -> IDLE, 00:00, running=0; the ss request is dropped.
REQ-037 rst_n low mid-LAP at 00:20 -> all outputs zero immediately; with the macro undefined, btn_lap in RUN -> no state change, lap_hold stays 0.
